pwm_duty_decode: RTL and testbench

- Receive-side counterpart of the motor PWM drive: observes one motor's fwd/rev PWM pair and recovers the commanded signed drive value.
- Reports brake (both high), coast (both low) and illegal-overlap fault per measurement window.
- Sits on the motor-driver pins. Feeds self-check/telemetry logic and closed-loop sanity monitors.

---
 rtl/pwm_duty_decode.sv | 152 +++++++++++++++
 tb/tb_pwm_duty_decode.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decode.sv
// Recovers the signed drive value from a motor's fwd/rev PWM pair over 2^PWM_W-cycle windows.
// Optional two-window averaging of the duty output: define PWM_DECODE_AVG_EN.
module pwm_duty_decode #(
  parameter int PWM_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fwd,
  input  logic               rev,
  output logic signed [PWM_W:0] duty,
  output logic               valid,
  output logic               brake,
  output logic               coast,
  output logic               fault
);

  localparam logic [PWM_W:0] FULL = {1'b1, {PWM_W{1'b0}}};
  localparam logic [PWM_W:0] MAXV = {1'b0, {PWM_W{1'b1}}};

  logic                   fwd_q, rev_q;
  logic [PWM_W-1:0]       win_q, win_d;
  logic [PWM_W:0]         fcnt_q, fcnt_d, rcnt_q, rcnt_d;
  logic signed [PWM_W:0]  duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   brake_q, brake_d;
  logic                   coast_q, coast_d;
  logic                   fault_q, fault_d;

  logic                   win_end;
  logic [PWM_W:0]         f_tot, r_tot, f_clip, r_clip;
  logic signed [PWM_W:0]  raw;
  logic signed [PWM_W:0]  good_val;
  logic                   good, sel_brake, sel_coast, sel_fault;

  assign win_end = &win_q;
  // Window totals include the sample being counted on the closing edge.
  assign f_tot   = fcnt_q + {{PWM_W{1'b0}}, fwd_q};
  assign r_tot   = rcnt_q + {{PWM_W{1'b0}}, rev_q};
  assign f_clip  = (f_tot == FULL) ? MAXV : f_tot;
  assign r_clip  = (r_tot == FULL) ? MAXV : r_tot;

  always_comb begin
    raw       = '0;
    good      = 1'b0;
    sel_brake = 1'b0;
    sel_coast = 1'b0;
    sel_fault = 1'b0;
    if (f_tot == FULL && r_tot == FULL) begin
      sel_brake = 1'b1;
    end else if (f_tot == '0 && r_tot == '0) begin
      sel_coast = 1'b1;
    end else if (r_tot == '0) begin
      good = 1'b1;
      raw  = signed'(f_clip);
    end else if (f_tot == '0) begin
      good = 1'b1;
      raw  = -signed'(r_clip);
    end else begin
      sel_fault = 1'b1;
    end
  end

`ifdef PWM_DECODE_AVG_EN
  logic signed [PWM_W:0]   hist_q, hist_d;
  logic                    hist_vld_q, hist_vld_d;
  logic signed [PWM_W+1:0] pair_sum;

  // Sum one bit wider so the arithmetic shift floors toward -inf without overflow.
  assign pair_sum = {raw[PWM_W], raw} + {hist_q[PWM_W], hist_q};
  assign good_val = hist_vld_q ? signed'((PWM_W+1)'(pair_sum >>> 1)) : raw;

  always_comb begin
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (win_end) begin
      if (good) begin
        hist_d     = raw;
        hist_vld_d = 1'b1;
      end else begin
        hist_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end
`else
  assign good_val = raw;
`endif

  always_comb begin
    win_d   = win_q + PWM_W'(1);
    fcnt_d  = win_end ? '0 : f_tot;
    rcnt_d  = win_end ? '0 : r_tot;
    valid_d = win_end;
    duty_d  = duty_q;
    brake_d = brake_q;
    coast_d = coast_q;
    fault_d = fault_q;
    if (win_end) begin
      brake_d = sel_brake;
      coast_d = sel_coast;
      fault_d = sel_fault;
      // A fault window keeps the last trustworthy duty.
      if (good) begin
        duty_d = good_val;
      end else if (!sel_fault) begin
        duty_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      win_q   <= '0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      brake_q <= 1'b0;
      coast_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fwd_q   <= fwd;
      rev_q   <= rev;
      win_q   <= win_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      brake_q <= brake_d;
      coast_q <= coast_d;
      fault_q <= fault_d;
    end
  end

  assign duty  = duty_q;
  assign valid = valid_q;
  assign brake = brake_q;
  assign coast = coast_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pwm_duty_decode.sv
// Bench for pwm_duty_decode: table vectors, hand sequences and random windows vs. a window-level model.
// Build with PWM_DECODE_AVG_EN defined to exercise the averaging variant.
module tb_pwm_duty_decode;

  localparam int W = 10;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fwd = 1'b0;
  logic rev = 1'b0;
  logic signed [W:0] duty;
  logic valid, brake, coast, fault;

  pwm_duty_decode #(.PWM_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .fwd(fwd), .rev(rev),
    .duty(duty), .valid(valid), .brake(brake), .coast(coast), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int u_next = 1;
  int f_hi = 0, f_ph = 0, r_hi = 0, r_ph = 0;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference model: collects one window's worth of samples seen by the decoder
  // (pins delayed one edge, reset sample is 0) and classifies the totals.
  logic [1:0] smp[$];
  int  m_duty = 0;
  bit  m_valid = 0, m_brake = 0, m_coast = 0, m_fault = 0;
  bit  h_ok = 0;
  int  h_val = 0;

  function automatic int floor_half(int s);
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  always @(posedge clk) begin : model
    int fc, rc, rawv;
    if (!rst_n) begin
      smp.delete();
      smp.push_back(2'b00);
      h_ok = 0; m_duty = 0; m_valid = 0; m_brake = 0; m_coast = 0; m_fault = 0;
    end else begin
      m_valid = 0;
      if (smp.size() == N) begin
        fc = 0; rc = 0;
        foreach (smp[i]) begin
          fc += int'(smp[i][1]);
          rc += int'(smp[i][0]);
        end
        smp.delete();
        m_valid = 1;
        m_brake = 0; m_coast = 0; m_fault = 0;
        if (fc == N && rc == N) begin
          m_brake = 1; m_duty = 0; h_ok = 0;
        end else if (fc == 0 && rc == 0) begin
          m_coast = 1; m_duty = 0; h_ok = 0;
        end else if (fc == 0 || rc == 0) begin
          rawv = (rc == 0) ? ((fc > N - 1) ? N - 1 : fc) : -((rc > N - 1) ? N - 1 : rc);
`ifdef PWM_DECODE_AVG_EN
          m_duty = h_ok ? floor_half(rawv + h_val) : rawv;
          h_val = rawv;
          h_ok = 1;
`else
          m_duty = rawv;
`endif
        end else begin
          m_fault = 1; h_ok = 0;
        end
      end
      smp.push_back({fwd, rev});
    end
  end

  always @(negedge clk) begin
    check("mdl_valid", int'(valid), int'(m_valid));
    check("mdl_duty", int'(duty), m_duty);
    check("mdl_brake", int'(brake), int'(m_brake));
    check("mdl_coast", int'(coast), int'(m_coast));
    check("mdl_fault", int'(fault), int'(m_fault));
  end

  function automatic logic pin(int hi, int ph, int u);
    return ((u + ph) % N) >= (N - hi);
  endfunction

  task automatic set_pat(int fh, int fp, int rh, int rp);
    f_hi = fh; f_ph = fp; r_hi = rh; r_ph = rp;
  endtask

  task automatic step();
    fwd = pin(f_hi, f_ph, u_next);
    rev = pin(r_hi, r_ph, u_next);
    @(posedge clk);
    #1;
    u_next++;
  endtask

  // Drive the current pattern up to the last sample of the current window.
  task automatic window();
    do step(); while (u_next % N != 0);
  endtask

  task automatic expect_out(string tag, int d, bit b, bit c, bit f);
    check({tag, "_valid"}, int'(valid), 1);
    check({tag, "_duty"}, int'(duty), d);
    check({tag, "_brake"}, int'(brake), int'(b));
    check({tag, "_coast"}, int'(coast), int'(c));
    check({tag, "_fault"}, int'(fault), int'(f));
  endtask

  typedef struct {
    int fh, fp, rh, rp;
    int d;
    bit b, c, f;
  } vec_t;

  vec_t tbl[9];

`ifdef PWM_DECODE_AVG_EN
  localparam int SEQ_SECOND = 384;
`else
  localparam int SEQ_SECOND = 256;
`endif

  initial begin
    int seen;
    int mode;
    tbl[0] = '{512, 0,   0,   0,   512,   1'b0, 1'b0, 1'b0};
    tbl[1] = '{0,   0,   256, 300, -256,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{N,   0,   N,   0,   0,     1'b1, 1'b0, 1'b0};
    tbl[3] = '{0,   0,   0,   0,   0,     1'b0, 1'b1, 1'b0};
    tbl[4] = '{N,   0,   0,   0,   1023,  1'b0, 1'b0, 1'b0};
    tbl[5] = '{0,   0,   N,   0,   -1023, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{128, 17,  0,   0,   128,   1'b0, 1'b0, 1'b0};
    tbl[7] = '{100, 0,   50,  500, 128,   1'b0, 1'b0, 1'b1};
    tbl[8] = '{128, 0,   0,   0,   128,   1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_duty", int'(duty), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_flags", int'({brake, coast, fault}), 0);
    rst_n = 1'b1;
    u_next = 1;

    // Each table pattern runs two windows; the second (pure) window is checked.
    set_pat(tbl[0].fh, tbl[0].fp, tbl[0].rh, tbl[0].rp);
    window(); window();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) set_pat(tbl[i+1].fh, tbl[i+1].fp, tbl[i+1].rh, tbl[i+1].rp);
      else       set_pat(0, 0, 0, 0);
      step();
      expect_out($sformatf("tbl%0d", i), tbl[i].d, tbl[i].b, tbl[i].c, tbl[i].f);
      if (i == 1) check("tbl1_bits", int'($unsigned(duty)), 'h700);
      $display("vector %0d: duty=%0d brake=%0b coast=%0b fault=%0b", i, duty, brake, coast, fault);
      if (i < 8) begin
        window(); window();
      end
    end

    // Back-to-back windows: +512, +256, brake, +100.
    window();
    set_pat(512, 0, 0, 0); window();
    set_pat(256, 0, 0, 0); step(); expect_out("seq_512", 512, 0, 0, 0); window();
    set_pat(N, 0, N, 0);   step(); expect_out("seq_256", SEQ_SECOND, 0, 0, 0); window();
    set_pat(100, 0, 0, 0); step(); expect_out("seq_brake", 0, 1, 0, 0); window();
    set_pat(0, 0, 0, 0);   step(); expect_out("seq_100", 100, 0, 0, 0);
    $display("sequence: last duty=%0d", duty);

    // Reset in the middle of a window, then time the first valid.
    set_pat(512, 0, 0, 0);
    repeat (300) step();
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("midrst_duty", int'(duty), 0);
    check("midrst_out", int'({valid, brake, coast, fault}), 0);
    rst_n = 1'b1;
    u_next = 1;
    set_pat(N, 0, 0, 0);
    seen = 0;
    repeat (N - 1) begin
      step();
      if (valid) seen++;
    end
    check("midrst_early_valid", seen, 0);
    step();
    check("midrst_first_valid", int'(valid), 1);
    check("midrst_first_duty", int'(duty), 1023);
    $display("reset: first valid duty=%0d", duty);

    // Random windows, checked by the model on every cycle.
    for (int k = 0; k < 16; k++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: set_pat($urandom_range(0, N), $urandom_range(0, N - 1), 0, 0);
        1: set_pat(0, 0, $urandom_range(0, N), $urandom_range(0, N - 1));
        2: set_pat($urandom_range(1, N), $urandom_range(0, N - 1),
                   $urandom_range(1, N), $urandom_range(0, N - 1));
        3: set_pat(N, 0, N, 0);
        default: set_pat(0, 0, 0, 0);
      endcase
      window();
      $display("random %0d: mode=%0d f_hi=%0d r_hi=%0d duty=%0d", k, mode, f_hi, r_hi, duty);
    end
    set_pat(0, 0, 0, 0);
    step();
    window();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
